trdb_resync_ctrl: RTL

TRDB_RESYNC_CTRL -- requirements
Module: trdb_resync_ctrl

---
 rtl/trdb_resync_ctrl_if.sv | 24 ++
 rtl/trdb_resync_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/trdb_resync_ctrl_if.sv
// Control/status bundle between the trace resync counter and its
// controller (the master drives the stimulus side and the slave is the counter).
interface trdb_resync_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             trace_enabled_i;
   logic             mode_i;
   logic             packet_emitted_i;
   logic [CNT_W-1:0] threshold_i;
   logic             resync_rst_i;
   logic             resync_max_o;
   logic [CNT_W-1:0] count_o;
   logic             missed_o;

   modport master (
      output trace_enabled_i, mode_i, packet_emitted_i, threshold_i, resync_rst_i,
      input  resync_max_o, count_o, missed_o
   );

   modport slave (
      input  trace_enabled_i, mode_i, packet_emitted_i, threshold_i, resync_rst_i,
      output resync_max_o, count_o, missed_o
   );
endinterface

// File: rtl/trdb_resync_ctrl.sv
// Trace resync period counter: counts cycles or packets up to a threshold and
// holds a resync request until it is acknowledged.
//
// state | meaning
// IDLE  | tracer off, counter held at 0
// COUNT | tracer on, counting increment events toward threshold
// PEND  | threshold reached, request held, counter frozen until ack
module trdb_resync_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   trdb_resync_ctrl_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      PEND  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             missed_q, missed_d;
   logic             resync_max_q, resync_max_d;
   logic             inc_ev;
   logic             thr_hit;

   assign inc_ev  = bus.trace_enabled_i & (~bus.mode_i | bus.packet_emitted_i);
   // Using >= so a threshold lowered below the running count still trips on the next event.
   assign thr_hit = cnt_q >= (bus.threshold_i - CNT_W'(1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      missed_d = missed_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.trace_enabled_i) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (!bus.trace_enabled_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.resync_rst_i) begin
               cnt_d = '0;
            end else if ((bus.threshold_i != '0) && inc_ev) begin
               if (thr_hit) begin
                  cnt_d   = bus.threshold_i;
                  state_d = PEND;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         PEND: begin
            if (bus.resync_rst_i) begin
               cnt_d    = '0;
               missed_d = 1'b0;
               state_d  = bus.trace_enabled_i ? COUNT : IDLE;
            end else if (inc_ev) begin
               missed_d = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            missed_d = 1'b0;
         end
      endcase
      resync_max_d = (state_d == PEND);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         missed_q     <= 1'b0;
         resync_max_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         missed_q     <= missed_d;
         resync_max_q <= resync_max_d;
      end
   end

   assign bus.resync_max_o = resync_max_q;
   assign bus.count_o      = cnt_q;
   assign bus.missed_o     = missed_q;

endmodule
